// File: rtl/operand_stager.sv
// rtl/operand_stager.sv - operand pairing and result capture for the 16-bit NAND logic stage
// Pairs incoming words into A/B (or A plus the last result) and registers the stage result.
module operand_stager #(
   parameter int K  = 16,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [K-1:0]  in_data,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          acc_mode,
   output logic [K-1:0]  opA,
   output logic [K-1:0]  opB,
   output logic          op_valid,
   input  logic          op_ready,
   input  logic [K-1:0]  result_in,
   output logic [K-1:0]  result_out,
   output logic          result_valid,
   output logic          acc_valid,
   output logic [CW-1:0] pair_count
);

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      ISSUE  = 2'd2
   } stagerState_t;

   stagerState_t state;
   stagerState_t nextState;

   logic [K-1:0]  accumulator;
   logic          wordXfer;
   logic          loadA;
   logic          loadB;
   logic          loadBFromAcc;
   logic          completeOp;

   assign in_ready = (state != ISSUE);
   assign wordXfer = in_valid && in_ready;

   always_comb begin
      nextState    = state;
      loadA        = 1'b0;
      loadB        = 1'b0;
      loadBFromAcc = 1'b0;
      completeOp   = 1'b0;
      case (state)
         LOAD_A: begin
            if (wordXfer) begin
               loadA = 1'b1;
               // Chaining needs a prior result; otherwise fall back to a normal B load.
               if (acc_mode && acc_valid) begin
                  loadBFromAcc = 1'b1;
                  nextState    = ISSUE;
               end else begin
                  nextState = LOAD_B;
               end
            end
         end
         LOAD_B: begin
            if (wordXfer) begin
               loadB     = 1'b1;
               nextState = ISSUE;
            end
         end
         ISSUE: begin
            if (op_ready) begin
               completeOp = 1'b1;
               nextState  = LOAD_A;
            end
         end
         default: nextState = LOAD_A;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= LOAD_A;
      end else begin
         state <= nextState;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opA <= '0;
         opB <= '0;
      end else begin
         if (loadA) begin
            opA <= in_data;
         end
         if (loadB) begin
            opB <= in_data;
         end else if (loadBFromAcc) begin
            opB <= accumulator;
         end
      end
   end

   // op_valid is a flop that mirrors "next state is ISSUE", so it is high exactly while in ISSUE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_valid     <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         op_valid     <= (nextState == ISSUE);
         result_valid <= completeOp;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_out  <= '0;
         accumulator <= '0;
         acc_valid   <= 1'b0;
         pair_count  <= '0;
      end else if (completeOp) begin
         result_out  <= result_in;
         accumulator <= result_in;
         acc_valid   <= 1'b1;
         pair_count  <= pair_count + 1'b1;
      end
   end

endmodule
